// File: rtl/samcoupe_cegen.sv
// Clock-enable and contention-wait generator for the SAM Coupe core.
// All enables are registered one clock after the counter value they decode.
module samcoupe_cegen #(
    parameter int CNT_W    = 4,
    parameter int PSG_DIV  = 12,
    parameter int NCH      = 2,
    parameter int WAIT_MAX = 64
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic           turbo,
    input  logic [NCH-1:0] cont_en,
    input  logic [NCH-1:0] acc,
    input  logic [NCH-1:0] cont,
    output logic           ce_fast,
    output logic           ce_p,
    output logic           ce_n,
    output logic           ce_cpu_p,
    output logic           ce_cpu_n,
    output logic           ce_psg,
    output logic           cpu_en,
    output logic [NCH-1:0] wait_act,
    output logic           wait_timeout
);

    localparam int TMO_W = $clog2(WAIT_MAX + 1);
    localparam int PSG_W = $clog2(PSG_DIV);

    localparam logic [CNT_W-1:0] C_HALF     = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-2:0] C_QTR      = (CNT_W - 1)'(1 << (CNT_W - 2));
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(WAIT_MAX - 1);
    localparam logic [PSG_W-1:0] C_PSG_LAST = PSG_W'(PSG_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [PSG_W-1:0] r_psg_cnt;
    logic             r_turbo_q;
    logic [NCH-1:0]   r_acc_q;
    logic [NCH-1:0]   r_cont_q;
    logic [NCH-1:0]   r_wait;
    logic [TMO_W-1:0] r_tmo [NCH];
    logic             r_cpu_en;
    logic             r_ce_fast;
    logic             r_ce_p;
    logic             r_ce_n;
    logic             r_ce_psg;
    logic             r_timeout;

    logic             w_slot;
    logic             w_nphase;
    logic [NCH-1:0]   w_wait_nxt;
    logic [TMO_W-1:0] w_tmo_nxt [NCH];
    logic             w_timeout_nxt;

    // In turbo the period halves, so only the low CNT_W-1 counter bits matter.
    always_comb begin
        w_slot   = r_turbo_q ? (r_cnt[CNT_W-2:0] == '0)    : (r_cnt == '0);
        w_nphase = r_turbo_q ? (r_cnt[CNT_W-2:0] == C_QTR) : (r_cnt == C_HALF);
    end

    always_comb begin
        w_wait_nxt    = r_wait;
        w_timeout_nxt = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_tmo_nxt[i] = r_tmo[i];
            if (r_turbo_q || !cont_en[i]) begin
                w_wait_nxt[i] = 1'b0;
                w_tmo_nxt[i]  = '0;
            end else if (r_cont_q[i] && !cont[i]) begin
                w_wait_nxt[i] = 1'b0;
            end else if (r_wait[i] && w_slot && (r_tmo[i] == C_TMO_LAST)) begin
                w_wait_nxt[i] = 1'b0;
                w_tmo_nxt[i]  = '0;
                w_timeout_nxt = 1'b1;
            end else if (!r_acc_q[i] && acc[i] && cont[i]) begin
                w_wait_nxt[i] = 1'b1;
                w_tmo_nxt[i]  = '0;
            end else if (r_wait[i] && w_slot) begin
                w_tmo_nxt[i] = r_tmo[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_psg_cnt <= '0;
            r_turbo_q <= 1'b0;
            r_acc_q   <= '0;
            r_cont_q  <= '0;
            r_wait    <= '0;
            for (int i = 0; i < NCH; i++) r_tmo[i] <= '0;
            r_cpu_en  <= 1'b1;
            r_ce_fast <= 1'b0;
            r_ce_p    <= 1'b0;
            r_ce_n    <= 1'b0;
            r_ce_psg  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_psg_cnt <= (r_psg_cnt == C_PSG_LAST) ? '0 : r_psg_cnt + 1'b1;
            // Mode only changes at a period boundary so no half-period glitch.
            if (r_cnt == '0) r_turbo_q <= turbo;
            r_acc_q   <= acc;
            r_cont_q  <= cont;
            r_wait    <= w_wait_nxt;
            for (int i = 0; i < NCH; i++) r_tmo[i] <= w_tmo_nxt[i];
            if (w_slot) r_cpu_en <= ~|r_wait;
            r_ce_fast <= (r_cnt[1:0] == 2'b00);
            r_ce_p    <= w_slot;
            r_ce_n    <= w_nphase;
            r_ce_psg  <= (r_psg_cnt == '0);
            r_timeout <= w_timeout_nxt;
        end
    end

    assign ce_fast      = r_ce_fast;
    assign ce_p         = r_ce_p;
    assign ce_n         = r_ce_n;
    assign ce_cpu_p     = r_ce_p & r_cpu_en;
    assign ce_cpu_n     = r_ce_n & r_cpu_en;
    assign ce_psg       = r_ce_psg;
    assign cpu_en       = r_cpu_en;
    assign wait_act     = r_wait;
    assign wait_timeout = r_timeout;

endmodule

// File: tb/tb_samcoupe_cegen.sv
// Bench for samcoupe_cegen: default instance plus a WAIT_MAX=4 instance on shared inputs.
module tb_samcoupe_cegen;

    localparam int P       = 16;
    localparam int PSG_DIV = 12;
    localparam int NCH     = 2;
    localparam logic [9:0] RST_V = 10'h008;

    logic           clk_sys = 1'b0;
    logic           rst_n   = 1'b1;
    logic           turbo   = 1'b0;
    logic [NCH-1:0] cont_en = '0;
    logic [NCH-1:0] acc     = '0;
    logic [NCH-1:0] cont    = '0;

    logic a_ce_fast, a_ce_p, a_ce_n, a_ce_cpu_p, a_ce_cpu_n, a_ce_psg, a_cpu_en, a_wait_timeout;
    logic b_ce_fast, b_ce_p, b_ce_n, b_ce_cpu_p, b_ce_cpu_n, b_ce_psg, b_cpu_en, b_wait_timeout;
    logic [NCH-1:0] a_wait_act, b_wait_act;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    samcoupe_cegen dut_a (
        .clk_sys(clk_sys), .rst_n(rst_n), .turbo(turbo), .cont_en(cont_en), .acc(acc), .cont(cont),
        .ce_fast(a_ce_fast), .ce_p(a_ce_p), .ce_n(a_ce_n), .ce_cpu_p(a_ce_cpu_p), .ce_cpu_n(a_ce_cpu_n),
        .ce_psg(a_ce_psg), .cpu_en(a_cpu_en), .wait_act(a_wait_act), .wait_timeout(a_wait_timeout)
    );

    samcoupe_cegen #(.WAIT_MAX(4)) dut_b (
        .clk_sys(clk_sys), .rst_n(rst_n), .turbo(turbo), .cont_en(cont_en), .acc(acc), .cont(cont),
        .ce_fast(b_ce_fast), .ce_p(b_ce_p), .ce_n(b_ce_n), .ce_cpu_p(b_ce_cpu_p), .ce_cpu_n(b_ce_cpu_n),
        .ce_psg(b_ce_psg), .cpu_en(b_cpu_en), .wait_act(b_wait_act), .wait_timeout(b_wait_timeout)
    );

    logic [9:0] obs [2];
    always_comb begin
        obs[0] = {a_ce_fast, a_ce_p, a_ce_n, a_ce_cpu_p, a_ce_cpu_n, a_ce_psg, a_cpu_en, a_wait_timeout, a_wait_act};
        obs[1] = {b_ce_fast, b_ce_p, b_ce_n, b_ce_cpu_p, b_ce_cpu_n, b_ce_psg, b_cpu_en, b_wait_timeout, b_wait_act};
    end

    // Reference model: phase from clocks elapsed since reset, waits from the channel rules.
    int             m_cyc;
    bit             m_turbo;
    bit [NCH-1:0]   m_accp, m_contp;
    bit [NCH-1:0]   m_wait [2];
    int             m_hold [2][NCH];
    bit             m_cpu  [2];
    bit             m_to   [2];
    bit             e_fast, e_p, e_n, e_psg;
    logic [9:0]     exp_v  [2];

    always @(posedge clk_sys or negedge rst_n) begin
        int ph, per, wm;
        bit slot, fall, rise;
        if (!rst_n) begin
            m_cyc = 0; m_turbo = 0; m_accp = '0; m_contp = '0;
            e_fast = 0; e_p = 0; e_n = 0; e_psg = 0;
            for (int k = 0; k < 2; k++) begin
                m_wait[k] = '0; m_cpu[k] = 1; m_to[k] = 0;
                for (int i = 0; i < NCH; i++) m_hold[k][i] = 0;
            end
        end else begin
            ph   = m_cyc % P;
            per  = m_turbo ? P / 2 : P;
            slot = (ph % per) == 0;
            e_fast = (ph % 4) == 0;
            e_p    = slot;
            e_n    = (ph % per) == per / 2;
            e_psg  = (m_cyc % PSG_DIV) == 0;
            for (int k = 0; k < 2; k++) begin
                wm = (k == 0) ? 64 : 4;
                if (slot) m_cpu[k] = (m_wait[k] == 0);
                m_to[k] = 0;
                for (int i = 0; i < NCH; i++) begin
                    fall = m_contp[i] && !cont[i];
                    rise = !m_accp[i] && acc[i] && cont[i];
                    if (m_turbo || !cont_en[i]) begin
                        m_wait[k][i] = 0; m_hold[k][i] = 0;
                    end else if (fall) begin
                        m_wait[k][i] = 0;
                    end else if (m_wait[k][i] && slot && m_hold[k][i] == wm - 1) begin
                        m_wait[k][i] = 0; m_hold[k][i] = 0; m_to[k] = 1;
                    end else if (rise) begin
                        m_wait[k][i] = 1; m_hold[k][i] = 0;
                    end else if (m_wait[k][i] && slot) begin
                        m_hold[k][i]++;
                    end
                end
            end
            if (ph == 0) m_turbo = turbo;
            m_accp = acc; m_contp = cont;
            m_cyc++;
        end
        for (int k = 0; k < 2; k++)
            exp_v[k] = {e_fast, e_p, e_n, e_p & m_cpu[k], e_n & m_cpu[k], e_psg, m_cpu[k], m_to[k], m_wait[k]};
    end

    task automatic do_reset();
        rst_n = 1'b0; turbo = 1'b0; cont_en = '0; acc = '0; cont = '0;
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== RST_V) begin bad++; $display("FAIL reset_state inst=%0d got=%b exp=%b", k, obs[k], RST_V); end
        end
        repeat (3) @(negedge clk_sys);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL reset_hold inst=%0d got=%b exp=%b", k, obs[k], exp_v[k]); end
        end
    endtask

    task automatic test_normal();
        logic [4:0] want;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_sys);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL normal_model inst=%0d n=%0d got=%b exp=%b", k, n, obs[k], exp_v[k]); end
            end
            want = {(n % 16) == 1, (n % 16) == 9, (n % 4) == 1, (n % 12) == 1, 1'b1};
            total++;
            if ({a_ce_p, a_ce_n, a_ce_fast, a_ce_psg, a_cpu_en} !== want) begin
                bad++; $display("FAIL normal_enables n=%0d got=%b exp=%b", n, {a_ce_p, a_ce_n, a_ce_fast, a_ce_psg, a_cpu_en}, want);
            end
        end
    endtask

    task automatic test_wait(input logic [NCH-1:0] en);
        do_reset();
        cont_en = en; cont = 2'b01;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk_sys);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL wait_model en=%b inst=%0d n=%0d got=%b exp=%b", en, k, n, obs[k], exp_v[k]); end
            end
            if (en[0]) begin
                if (n == 5 || n == 6 || n == 40 || n == 41) begin
                    total++;
                    if (a_wait_act[0] !== (n == 6 || n == 40)) begin bad++; $display("FAIL wait_flag n=%0d got=%b", n, a_wait_act[0]); end
                end
                if (n == 16 || n == 17 || n == 33 || n == 48 || n == 49) begin
                    total++;
                    if (a_cpu_en !== (n == 16 || n == 49)) begin bad++; $display("FAIL wait_cpu_en n=%0d got=%b", n, a_cpu_en); end
                end
                if (n == 17 || n == 33) begin
                    total++;
                    if (a_ce_cpu_p !== 1'b0 || a_ce_p !== 1'b1) begin bad++; $display("FAIL wait_gated n=%0d ce_cpu_p=%b ce_p=%b exp 0/1", n, a_ce_cpu_p, a_ce_p); end
                end
            end else begin
                total++;
                if (a_wait_act !== 2'b00 || a_ce_cpu_p !== a_ce_p) begin
                    bad++; $display("FAIL masked n=%0d wait_act=%b ce_cpu_p=%b ce_p=%b", n, a_wait_act, a_ce_cpu_p, a_ce_p);
                end
            end
            if (n == 5) acc[0] = 1'b1;
            if (n == 40) cont[0] = 1'b0;
        end
    endtask

    task automatic test_turbo();
        logic [2:0] want;
        do_reset();
        cont_en = 2'b11; cont = 2'b01;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk_sys);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL turbo_model inst=%0d n=%0d got=%b exp=%b", k, n, obs[k], exp_v[k]); end
            end
            if (n <= 33) want = {((n - 1) % 16) == 0, ((n - 1) % 16) == 8, ((n - 1) % 4) == 0};
            else         want = {((n - 1) % 8) == 0,  ((n - 1) % 8) == 4,  ((n - 1) % 4) == 0};
            total++;
            if ({a_ce_p, a_ce_n, a_ce_fast} !== want) begin bad++; $display("FAIL turbo_phase n=%0d got=%b exp=%b", n, {a_ce_p, a_ce_n, a_ce_fast}, want); end
            if (n == 20 || n >= 34) begin
                total++;
                if (a_wait_act[0] !== (n == 20)) begin bad++; $display("FAIL turbo_wait n=%0d got=%b", n, a_wait_act[0]); end
            end
            if (n == 10) acc[0] = 1'b1;
            if (n == 20) turbo = 1'b1;
            if (n >= 40 && (n % 3) == 0) acc[0] = ~acc[0];
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        cont_en = 2'b10; cont = 2'b10;
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk_sys);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL timeout_model inst=%0d n=%0d got=%b exp=%b", k, n, obs[k], exp_v[k]); end
            end
            if (b_wait_timeout === 1'b1) pulses++;
            if (n == 64 || n == 65) begin
                total++;
                if ({b_wait_act[1], b_wait_timeout} !== ((n == 64) ? 2'b10 : 2'b01)) begin
                    bad++; $display("FAIL timeout_edge n=%0d wait/tmo got=%b", n, {b_wait_act[1], b_wait_timeout});
                end
            end
            if (n == 80 || n == 81) begin
                total++;
                if (b_cpu_en !== (n == 81)) begin bad++; $display("FAIL timeout_cpu_en n=%0d got=%b", n, b_cpu_en); end
            end
            if (n == 2) acc[1] = 1'b1;
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
        total++;
        if ({a_wait_act[1], a_cpu_en} !== 2'b10) begin bad++; $display("FAIL timeout_long_hold got=%b exp=10", {a_wait_act[1], a_cpu_en}); end
    endtask

    task automatic test_clear_reset();
        do_reset();
        cont_en = 2'b01; cont = 2'b01;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_sys);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL clear_model inst=%0d n=%0d got=%b exp=%b", k, n, obs[k], exp_v[k]); end
            end
            if (n == 6 || n == 12 || n == 20) begin
                total++;
                if ({a_wait_act[0], a_cpu_en} !== ((n == 6) ? 2'b01 : (n == 12) ? 2'b11 : 2'b10)) begin
                    bad++; $display("FAIL clear_wins n=%0d wait/cpu_en got=%b", n, {a_wait_act[0], a_cpu_en});
                end
            end
            if (n == 5) begin cont[0] = 1'b0; acc[0] = 1'b1; end
            if (n == 7) begin cont[0] = 1'b1; acc[0] = 1'b0; end
            if (n == 9) acc[0] = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== RST_V) begin bad++; $display("FAIL async_reset inst=%0d got=%b exp=%b", k, obs[k], RST_V); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 1; n <= 4000; n++) begin
            @(negedge clk_sys);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL random_model inst=%0d n=%0d got=%b exp=%b", k, n, obs[k], exp_v[k]); end
            end
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(7) == 0)   acc[i]     = ~acc[i];
                if ($urandom_range(39) == 0)  cont[i]    = ~cont[i];
                if ($urandom_range(249) == 0) cont_en[i] = ~cont_en[i];
            end
            if ($urandom_range(299) == 0) turbo = ~turbo;
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_wait(2'b01);
        test_wait(2'b00);
        test_turbo();
        test_timeout();
        test_clear_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
